fb_reader: RTL and testbench
============================

# fb_reader

Pipelined framebuffer pixel reader: accepts pixel read requests (SRAM word address plus opaque metadata) on a valid/ready stream and issues AXI-lite reads to the SRAM controller's read port. It returns color, metadata and an error flag on an in-order valid/ready response stream. It is the read-side counterpart of `fb_writer` and enables graphics readback (blend, read-modify-write, copy) alongside the display path. It keeps up to MAX_OUTSTANDING reads in flight and never stalls the R channel.

## Interface
- PIXEL_BITS, 12, color bits returned; must be ≤ AXI_DATA_WIDTH
- AXI_ADDR_WIDTH, 20, SRAM word address width
- AXI_DATA_WIDTH, 16, SRAM data width
- META_BITS, 4, opaque per-request tag carried to the response
- MAX_OUTSTANDING, 4, in-flight plus buffered limit; power of two, ≥ 2

Ports:
- axi_clk  in  1  sole clock
- axi_resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  AXI_ADDR_WIDTH  pixel word address
- req_meta  in  META_BITS  tag
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer ready
- resp_color  out  PIXEL_BITS  rdata[PIXEL_BITS-1:0]
- resp_meta  out  META_BITS  tag of matching request
- resp_err  out  1  rresp != 2'b00
- sram_axi_araddr  out  AXI_ADDR_WIDTH  read address
- sram_axi_arvalid  out  1
- sram_axi_arready  in  1
- sram_axi_rdata  in  AXI_DATA_WIDTH
- sram_axi_rresp  in  2
- sram_axi_rvalid  in  1
- sram_axi_rready  out  1
- busy  out  1  credits in use != 0

## Operation
- credit counter `used`, width $clog2(MAX_OUTSTANDING+1): +1 on request accept, −1 on response handshake (resp_valid&resp_ready); both in one cycle → unchanged.
- req_ready = (used < MAX_OUTSTANDING) && (!arvalid || arready). Combinational; does not depend on req_valid.
- Accept: register araddr ← req_addr, arvalid ← 1; push req_meta into meta FIFO same edge.
- arvalid held with araddr stable until arready; back-to-back accept allowed in the arready cycle (AR register reloads).
- sram_axi_rready = 1 whenever out of reset; space guaranteed by credits.
- On rvalid: pop meta FIFO, push {rdata[PIXEL_BITS-1:0], meta, |rresp} into response FIFO. Upper rdata bits ignored.
- resp_* = response FIFO head; resp_valid = !empty. Pop on resp_valid&resp_ready.
- Responses strictly in request order; AXI read port is in-order.
- rvalid with empty meta FIFO: protocol violation → simulation assertion; beat dropped, no state change.
- resp_err beats still consume/return credit normally; color forwarded unmodified.

## Timing
- Reset values: req_ready 0 (during reset), arvalid 0, araddr 0, rready 0, resp_valid 0, resp_color/meta/err 0, busy 0, used 0, FIFOs empty.
- Reset mid-operation: all in-flight and buffered transactions discarded; SRAM controller shares reset, so no stale R beats arrive.
- Request accepted at edge N → arvalid high from N+1.
- rvalid handshake at edge M → resp_valid high from M+1 (response FIFO registered write, combinational head read).
- Minimum request-to-response: 2 cycles + controller read latency.
- Throughput: one request and one response per cycle sustained, given arready and resp_ready held high, while used < MAX_OUTSTANDING.
- Full: used == MAX_OUTSTANDING → req_ready 0 until a response pops; reopens in the pop cycle (combinational on resp_ready).
- FIFO pointers wrap modulo MAX_OUTSTANDING with an extra bit for full/empty.

## Structure
- No shared-package types needed; parameters are local.
- One sub-module: `sync_fifo` (WIDTH, DEPTH; w_inc/r_inc, full/empty, async active-low reset). Instantiated twice: meta FIFO (META_BITS) and response FIFO (PIXEL_BITS+META_BITS+1).
- Credit counter and AR register live in fb_reader.

## Test plan
- Single read, addr 0x00123 preloaded 12'hABC, meta 4'h5 → one AR with araddr 0x00123; resp_color 12'hABC, resp_meta 5, resp_err 0.
- 8 back-to-back requests, addrs 0..7 with meta 0..7, arready/resp_ready high → responses in order, meta 0..7; steady state one per cycle.
- resp_ready low and 6 requests offered → exactly 4 accepted (req_ready drops at used=4); raise resp_ready → remaining 2 accepted, order preserved.
- arready held low 5 cycles → araddr/arvalid stable throughout, req_ready 0; request accepted in the arready cycle.
- Controller returns rresp=2'b10 for one beat → resp_err 1 for that beat only; credit released.
- axi_resetn asserted with 3 reads outstanding → outputs at reset values immediately; after release, used 0 and new read completes correctly.

Source files
------------

// File: rtl/fb_reader_pkg.sv
// Shared constants and helpers for the framebuffer pixel reader.
package fb_reader_pkg;

    localparam logic [1:0] RespOkay = 2'b00;

    // Any non-OKAY read response marks the returned pixel as erroneous.
    function automatic logic resp_is_err(input logic [1:0] rresp);
        return rresp != RespOkay;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// The head is read combinationally; writes are registered.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_w_inc,
    input  logic [WIDTH-1:0] i_w_data,
    input  logic             i_r_inc,
    output logic [WIDTH-1:0] o_r_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_write;
    logic             w_do_read;

    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_write = i_w_inc && !o_full;
    assign w_do_read  = i_r_inc && !o_empty;
    assign o_r_data   = r_mem[r_rptr[AW-1:0]];

    // Pointer update; wrap is implicit in the AW+1 bit arithmetic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_write) r_wptr <= r_wptr + 1'b1;
            if (w_do_read)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is cleared so the head reads as zero straight out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_write) begin
            r_mem[r_wptr[AW-1:0]] <= i_w_data;
        end
    end

endmodule

// File: rtl/fb_reader.sv
// Pipelined framebuffer pixel reader: turns pixel requests into AXI-lite
// reads and returns colour/tag/error in request order. A credit counter
// bounds in-flight plus buffered reads so the R channel never stalls.
module fb_reader
    import fb_reader_pkg::*;
#(
    parameter int unsigned PIXEL_BITS      = 12,
    parameter int unsigned AXI_ADDR_WIDTH  = 20,
    parameter int unsigned AXI_DATA_WIDTH  = 16,
    parameter int unsigned META_BITS       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                      axi_clk,
    input  logic                      axi_resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [META_BITS-1:0]      req_meta,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [PIXEL_BITS-1:0]     resp_color,
    output logic [META_BITS-1:0]      resp_meta,
    output logic                      resp_err,
    output logic [AXI_ADDR_WIDTH-1:0] sram_axi_araddr,
    output logic                      sram_axi_arvalid,
    input  logic                      sram_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] sram_axi_rdata,
    input  logic [1:0]                sram_axi_rresp,
    input  logic                      sram_axi_rvalid,
    output logic                      sram_axi_rready,
    output logic                      busy
);
    localparam int unsigned   CW         = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned   RW         = PIXEL_BITS + META_BITS + 1;
    localparam logic [CW-1:0] MaxCredits = CW'(MAX_OUTSTANDING);

    logic [CW-1:0]             r_used;
    logic [CW-1:0]             w_used_next;
    logic                      r_arvalid;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic                      r_rready;
    logic                      w_accept;
    logic                      w_resp_pop;
    logic                      w_r_beat;
    logic                      w_meta_empty;
    logic                      w_resp_empty;
    logic                      w_meta_full_unused;
    logic                      w_resp_full_unused;
    logic [META_BITS-1:0]      w_meta_head;
    logic [RW-1:0]             w_resp_wdata;
    logic [RW-1:0]             w_resp_head;
    logic [AXI_DATA_WIDTH-1:0] w_rdata_unused;

    // Upper rdata bits carry nothing for the pixel format.
    assign w_rdata_unused = sram_axi_rdata;

    assign w_resp_pop = !w_resp_empty && resp_ready;
    // A pop in this cycle frees a credit, so a full reader reopens at once.
    assign req_ready  = r_rready && ((r_used < MaxCredits) || w_resp_pop)
                        && (!r_arvalid || sram_axi_arready);
    assign w_accept   = req_valid && req_ready;
    assign w_r_beat   = sram_axi_rvalid && r_rready;

    assign w_resp_wdata = {sram_axi_rdata[PIXEL_BITS-1:0], w_meta_head,
                           resp_is_err(sram_axi_rresp)};
    assign {resp_color, resp_meta, resp_err} = w_resp_head;
    assign resp_valid       = !w_resp_empty;
    assign sram_axi_araddr  = r_araddr;
    assign sram_axi_arvalid = r_arvalid;
    assign sram_axi_rready  = r_rready;
    assign busy             = (r_used != '0);

    // Credit accounting: accept and pop in the same cycle cancel out.
    always_comb begin
        w_used_next = r_used;
        if (w_accept && !w_resp_pop) begin
            w_used_next = r_used + 1'b1;
        end else if (!w_accept && w_resp_pop) begin
            w_used_next = r_used - 1'b1;
        end
    end

    // Credit counter, AR register and the out-of-reset rready flag.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_used    <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b0;
        end else begin
            r_used   <= w_used_next;
            r_rready <= 1'b1;
            if (w_accept) begin
                r_arvalid <= 1'b1;
                r_araddr  <= req_addr;
            end else if (sram_axi_arready) begin
                r_arvalid <= 1'b0;
            end
        end
    end

    // Tags of reads issued but not yet answered.
    sync_fifo #(
        .WIDTH (META_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_meta_fifo (
        .i_clk    (axi_clk),
        .i_rst_n  (axi_resetn),
        .i_w_inc  (w_accept),
        .i_w_data (req_meta),
        .i_r_inc  (w_r_beat),
        .o_r_data (w_meta_head),
        .o_full   (w_meta_full_unused),
        .o_empty  (w_meta_empty)
    );

    // Completed pixels waiting for the consumer; a stray beat is dropped.
    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .i_clk    (axi_clk),
        .i_rst_n  (axi_resetn),
        .i_w_inc  (w_r_beat && !w_meta_empty),
        .i_w_data (w_resp_wdata),
        .i_r_inc  (w_resp_pop),
        .o_r_data (w_resp_head),
        .o_full   (w_resp_full_unused),
        .o_empty  (w_resp_empty)
    );

    // An R beat with nothing outstanding means the controller broke protocol.
    a_rvalid_has_meta : assert property (@(posedge axi_clk) disable iff (!axi_resetn)
                                         sram_axi_rvalid |-> !w_meta_empty);

endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader with an in-order, one-cycle-latency SRAM model.
module tb_fb_reader;
    localparam int unsigned PB = 12;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int unsigned MB = 4;
    localparam int unsigned MO = 4;

    logic          axi_clk = 1'b0;
    logic          axi_resetn;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [MB-1:0] req_meta;
    logic          resp_valid;
    logic          resp_ready;
    logic [PB-1:0] resp_color;
    logic [MB-1:0] resp_meta;
    logic          resp_err;
    logic [AW-1:0] sram_axi_araddr;
    logic          sram_axi_arvalid;
    logic          sram_axi_arready;
    logic [DW-1:0] sram_axi_rdata;
    logic [1:0]    sram_axi_rresp;
    logic          sram_axi_rvalid;
    logic          sram_axi_rready;
    logic          busy;

    fb_reader #(
        .PIXEL_BITS      (PB),
        .AXI_ADDR_WIDTH  (AW),
        .AXI_DATA_WIDTH  (DW),
        .META_BITS       (MB),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .axi_clk          (axi_clk),
        .axi_resetn       (axi_resetn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_meta         (req_meta),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_color       (resp_color),
        .resp_meta        (resp_meta),
        .resp_err         (resp_err),
        .sram_axi_araddr  (sram_axi_araddr),
        .sram_axi_arvalid (sram_axi_arvalid),
        .sram_axi_arready (sram_axi_arready),
        .sram_axi_rdata   (sram_axi_rdata),
        .sram_axi_rresp   (sram_axi_rresp),
        .sram_axi_rvalid  (sram_axi_rvalid),
        .sram_axi_rready  (sram_axi_rready),
        .busy             (busy)
    );

    always #5 axi_clk = ~axi_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SRAM contents: one hand-picked word, everything else a fixed pattern.
    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (a == 20'h00123) return 16'hFABC;
        return {4'hD, a[11:0] ^ 12'h3C5};
    endfunction

    // SRAM controller model: R beat one cycle after each AR handshake.
    logic [AW-1:0] ar_q[$];
    logic [AW-1:0] ar_log[$];
    always @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            sram_axi_rvalid <= 1'b0;
            sram_axi_rdata  <= '0;
            sram_axi_rresp  <= '0;
            ar_q.delete();
        end else begin
            if (sram_axi_arvalid && sram_axi_arready) begin
                ar_q.push_back(sram_axi_araddr);
                ar_log.push_back(sram_axi_araddr);
            end
            if (ar_q.size() > 0) begin
                sram_axi_rvalid <= 1'b1;
                sram_axi_rdata  <= mem_rd(ar_q[0]);
                sram_axi_rresp  <= (ar_q[0] == 20'h00300) ? 2'b10 : 2'b00;
                void'(ar_q.pop_front());
            end else begin
                sram_axi_rvalid <= 1'b0;
            end
        end
    end

    // Response collector.
    logic [PB-1:0] got_color[$];
    logic [MB-1:0] got_meta[$];
    logic          got_err[$];
    int            got_cyc[$];
    int            cyc = 0;
    always @(posedge axi_clk) begin
        cyc <= cyc + 1;
        if (axi_resetn && resp_valid && resp_ready) begin
            got_color.push_back(resp_color);
            got_meta.push_back(resp_meta);
            got_err.push_back(resp_err);
            got_cyc.push_back(cyc);
        end
    end

    logic [PB-1:0] exp_color[$];
    logic [MB-1:0] exp_meta[$];
    logic          exp_err[$];
    int            got_base = 0;
    int            ar_base  = 0;

    task automatic expect_resp(input logic [AW-1:0] a, input logic [MB-1:0] m, input logic e);
        logic [DW-1:0] d;
        d = mem_rd(a);
        exp_color.push_back(d[PB-1:0]);
        exp_meta.push_back(m);
        exp_err.push_back(e);
    endtask

    // Called at a negedge; holds the request until accepted or budget runs out.
    task automatic offer(input logic [AW-1:0] a, input logic [MB-1:0] m, input int budget,
                         output bit ok);
        bit hs;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_meta  = m;
        for (int c = 0; c < budget && !ok; c++) begin
            #1;
            hs = req_ready;
            @(posedge axi_clk);
            if (hs) ok = 1'b1;
            @(negedge axi_clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_resps(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && got_color.size() < got_base + n; c++) @(negedge axi_clk);
        check_eq({tag, "_count"}, got_color.size() - got_base, n);
    endtask

    task automatic compare_resps(input string tag);
        for (int i = 0; i < exp_color.size(); i++) begin
            if (got_base + i < got_color.size()) begin
                check_eq({tag, "_color"}, got_color[got_base+i], exp_color[i]);
                check_eq({tag, "_meta"}, got_meta[got_base+i], exp_meta[i]);
                check_eq({tag, "_err"}, got_err[got_base+i], exp_err[i]);
            end
        end
        got_base = got_color.size();
        exp_color.delete();
        exp_meta.delete();
        exp_err.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_arvalid"}, sram_axi_arvalid, 0);
        check_eq({tag, "_araddr"}, sram_axi_araddr, 0);
        check_eq({tag, "_rready"}, sram_axi_rready, 0);
        check_eq({tag, "_resp_valid"}, resp_valid, 0);
        check_eq({tag, "_resp_color"}, resp_color, 0);
        check_eq({tag, "_resp_meta"}, resp_meta, 0);
        check_eq({tag, "_resp_err"}, resp_err, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        bit ok;
        int n_ok;

        axi_resetn       = 1'b0;
        req_valid        = 1'b0;
        req_addr         = '0;
        req_meta         = '0;
        resp_ready       = 1'b1;
        sram_axi_arready = 1'b1;
        repeat (3) @(negedge axi_clk);
        check_reset_outputs("rst");
        axi_resetn = 1'b1;
        repeat (2) @(negedge axi_clk);
        check_eq("rst_rel_rready", sram_axi_rready, 1);
        check_eq("rst_rel_req_ready", req_ready, 1);

        // Single read of the preloaded word.
        ar_base = ar_log.size();
        offer(20'h00123, 4'h5, 4, ok);
        check_eq("t1_accept", ok, 1);
        check_eq("t1_arvalid", sram_axi_arvalid, 1);
        check_eq("t1_araddr", sram_axi_araddr, 20'h00123);
        check_eq("t1_busy", busy, 1);
        exp_color.push_back(12'hABC);
        exp_meta.push_back(4'h5);
        exp_err.push_back(1'b0);
        wait_resps("t1", 1, 20);
        compare_resps("t1");
        check_eq("t1_ar_count", ar_log.size() - ar_base, 1);
        if (ar_log.size() > ar_base) check_eq("t1_ar_addr", ar_log[ar_base], 20'h00123);
        repeat (2) @(negedge axi_clk);
        check_eq("t1_idle", busy, 0);

        // Eight back-to-back requests, each must go in the cycle it is offered.
        n_ok = 0;
        for (int i = 0; i < 8; i++) begin
            offer(AW'(i), MB'(i), 1, ok);
            n_ok += int'(ok);
            expect_resp(AW'(i), MB'(i), 1'b0);
        end
        check_eq("t2_accepted", n_ok, 8);
        wait_resps("t2", 8, 40);
        if (got_cyc.size() >= got_base + 8)
            check_eq("t2_resp_span", got_cyc[got_base+7] - got_cyc[got_base], 7);
        compare_resps("t2");

        // Consumer stalled: only MAX_OUTSTANDING requests get in.
        resp_ready = 1'b0;
        n_ok = 0;
        for (int k = 0; k < 6; k++) begin
            if (n_ok == k) begin
                offer(20'h00040 + AW'(k), MB'(k), 3, ok);
                n_ok += int'(ok);
            end
        end
        check_eq("t3_accepted_full", n_ok, 4);
        check_eq("t3_full_ready", req_ready, 0);
        check_eq("t3_full_busy", busy, 1);
        check_eq("t3_head_valid", resp_valid, 1);
        check_eq("t3_head_meta", resp_meta, 0);
        req_valid  = 1'b1;
        req_addr   = 20'h00044;
        req_meta   = 4'h4;
        resp_ready = 1'b1;
        #1;
        check_eq("t3_reopen", req_ready, 1);
        @(posedge axi_clk);
        @(negedge axi_clk);
        offer(20'h00045, 4'h5, 3, ok);
        check_eq("t3_last_accept", ok, 1);
        for (int k = 0; k < 6; k++) expect_resp(20'h00040 + AW'(k), MB'(k), 1'b0);
        wait_resps("t3", 6, 40);
        compare_resps("t3");

        // AR back-pressure: address held stable, intake closed, reload on arready.
        ar_base = ar_log.size();
        sram_axi_arready = 1'b0;
        offer(20'h00200, 4'h9, 2, ok);
        check_eq("t4_first_accept", ok, 1);
        req_valid = 1'b1;
        req_addr  = 20'h00201;
        req_meta  = 4'hA;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("t4_hold_addr", sram_axi_araddr, 20'h00200);
            check_eq("t4_hold_valid", sram_axi_arvalid, 1);
            check_eq("t4_hold_ready", req_ready, 0);
            @(negedge axi_clk);
        end
        sram_axi_arready = 1'b1;
        #1;
        check_eq("t4_reload_ready", req_ready, 1);
        @(posedge axi_clk);
        @(negedge axi_clk);
        req_valid = 1'b0;
        check_eq("t4_reload_addr", sram_axi_araddr, 20'h00201);
        check_eq("t4_reload_valid", sram_axi_arvalid, 1);
        expect_resp(20'h00200, 4'h9, 1'b0);
        expect_resp(20'h00201, 4'hA, 1'b0);
        wait_resps("t4", 2, 20);
        compare_resps("t4");
        check_eq("t4_ar_count", ar_log.size() - ar_base, 2);
        if (ar_log.size() >= ar_base + 2) begin
            check_eq("t4_ar0", ar_log[ar_base], 20'h00200);
            check_eq("t4_ar1", ar_log[ar_base+1], 20'h00201);
        end

        // One SLVERR beat in the middle of a burst of three.
        offer(20'h002FF, 4'h1, 2, ok);
        offer(20'h00300, 4'h2, 2, ok);
        offer(20'h00301, 4'h3, 2, ok);
        expect_resp(20'h002FF, 4'h1, 1'b0);
        expect_resp(20'h00300, 4'h2, 1'b1);
        expect_resp(20'h00301, 4'h3, 1'b0);
        wait_resps("t5", 3, 20);
        compare_resps("t5");
        repeat (3) @(negedge axi_clk);
        check_eq("t5_credit_free", busy, 0);

        // Reset with three reads buffered.
        resp_ready = 1'b0;
        offer(20'h00500, 4'hC, 2, ok);
        offer(20'h00501, 4'hD, 2, ok);
        offer(20'h00502, 4'hE, 2, ok);
        repeat (4) @(negedge axi_clk);
        check_eq("t6_pre_valid", resp_valid, 1);
        check_eq("t6_pre_busy", busy, 1);
        axi_resetn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) @(negedge axi_clk);
        axi_resetn = 1'b1;
        resp_ready = 1'b1;
        repeat (2) @(negedge axi_clk);
        check_eq("t6_no_stale", got_color.size() - got_base, 0);
        check_eq("t6_used_zero", busy, 0);
        ar_base = ar_log.size();
        offer(20'h00123, 4'h7, 4, ok);
        check_eq("t6_accept", ok, 1);
        exp_color.push_back(12'hABC);
        exp_meta.push_back(4'h7);
        exp_err.push_back(1'b0);
        wait_resps("t6", 1, 20);
        compare_resps("t6");
        if (ar_log.size() > ar_base) check_eq("t6_ar_addr", ar_log[ar_base], 20'h00123);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
